// File: rtl/ram_sched_pkg.sv
// ---------------------------------------------------------------------------
// ram_sched_pkg
// Shared types and default sizes for the frame-RAM write scheduler.
//   state_e : write sequencer states (ARB, SETUP, STROBE)
//   req_e   : requester identity (HOST, STRM)
//   *_DEF   : default address width, pixel width and frame length
// ---------------------------------------------------------------------------
package ram_sched_pkg;

  localparam int ADDR_W_DEF       = 18;
  localparam int DATA_W_DEF       = 8;
  localparam int FRAME_PIXELS_DEF = 262144;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_e;

  typedef enum logic {
    HOST = 1'b0,
    STRM = 1'b1
  } req_e;

endpackage

// File: rtl/ram_sched_arbiter.sv
// ---------------------------------------------------------------------------
// ram_sched_arbiter
// Two-way grant between the host loader and the result stream.
// Optional feature macro: ROUND_ROBIN_EN
//   defined   : on contention, grant the requester that did not win last;
//               last_grant resets to HOST so the first contention goes to STRM.
//   undefined : fixed priority, stream always wins (no history register).
// Ports:
//   Clock, Rst       : clock / async active-low reset (ROUND_ROBIN_EN only)
//   en_i             : arbiter may grant this cycle (ARB state, no finish)
//   host_valid_i     : host beat present
//   strm_valid_i     : stream beat present
//   grant_host_o     : host granted (combinational)
//   grant_strm_o     : stream granted (combinational)
// A grant is only issued to a valid requester, so a grant is a transfer.
// ---------------------------------------------------------------------------
module ram_sched_arbiter
  import ram_sched_pkg::*;
(
`ifdef ROUND_ROBIN_EN
  input  logic Clock,
  input  logic Rst,
`endif
  input  logic en_i,
  input  logic host_valid_i,
  input  logic strm_valid_i,
  output logic grant_host_o,
  output logic grant_strm_o
);

`ifdef ROUND_ROBIN_EN
  req_e last_grant_q, last_grant_d;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) last_grant_q <= HOST;
    else      last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_strm_o)      last_grant_d = STRM;
    else if (grant_host_o) last_grant_d = HOST;
  end
`endif

  always_comb begin
    grant_host_o = 1'b0;
    grant_strm_o = 1'b0;
    if (en_i) begin
      if (host_valid_i && strm_valid_i) begin
`ifdef ROUND_ROBIN_EN
        if (last_grant_q == HOST) grant_strm_o = 1'b1;
        else                      grant_host_o = 1'b1;
`else
        grant_strm_o = 1'b1;
`endif
      end else if (strm_valid_i) begin
        grant_strm_o = 1'b1;
      end else if (host_valid_i) begin
        grant_host_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_write_scheduler.sv
// ---------------------------------------------------------------------------
// ram_write_scheduler
// Write-side controller for the single-port frame RAM. Arbitrates host
// (addressed) and stream (sequential) beats, turns each accepted beat into a
// SETUP/STROBE pair so the RAM sees stable address/data before the rising
// edge of WriteEnable, and pulses finish once per frame of stream pixels.
// Optional feature macro: ROUND_ROBIN_EN (see ram_sched_arbiter).
//
// state  | meaning
// -------+-----------------------------------------------------------
// ARB    | idle / arbitrate; beat accepted on valid & ready
// SETUP  | Address/Data_In stable, WriteEnable low
// STROBE | WriteEnable high, RAM captures on its rising edge
//
// Ports:
//   Clock, Rst                 : clock, async active-low reset
//   host_valid/ready/addr/data : host loader write port
//   strm_valid/ready/data      : accelerator result stream
//   Address, Data_In           : registered RAM address / data
//   WriteEnable                : registered RAM write strobe
//   finish                     : one-cycle pulse after a frame's last pixel
//   busy                       : high in SETUP and STROBE
// ---------------------------------------------------------------------------
module ram_write_scheduler
  import ram_sched_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              strm_valid,
  output logic              strm_ready,
  input  logic [DATA_W-1:0] strm_data,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data_In,
  output logic              WriteEnable,
  output logic              finish,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

  state_e            state_q, state_d;
  req_e              src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              fin_q, fin_d;

  logic              arb_en;
  logic              grant_host, grant_strm;
  logic              xfer_host, xfer_strm, xfer;

  // No grant during the finish cycle so the RAM dump is not disturbed.
  assign arb_en = (state_q == ARB) && !fin_q;

  ram_sched_arbiter u_arb (
`ifdef ROUND_ROBIN_EN
    .Clock        (Clock),
    .Rst          (Rst),
`endif
    .en_i         (arb_en),
    .host_valid_i (host_valid),
    .strm_valid_i (strm_valid),
    .grant_host_o (grant_host),
    .grant_strm_o (grant_strm)
  );

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q <= ARB;
      src_q   <= HOST;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:     if (xfer) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    host_ready = grant_host;
    strm_ready = grant_strm;
    xfer_host  = host_valid && grant_host;
    xfer_strm  = strm_valid && grant_strm;
    xfer       = xfer_host || xfer_strm;

    addr_d = addr_q;
    data_d = data_q;
    src_d  = src_q;
    cnt_d  = cnt_q;
    fin_d  = 1'b0;

    if (xfer_host) begin
      addr_d = host_addr;
      data_d = host_data;
      src_d  = HOST;
    end else if (xfer_strm) begin
      addr_d = cnt_q;
      data_d = strm_data;
      src_d  = STRM;
    end

    // Stream address advances only once its write has been strobed.
    if (state_q == STROBE && src_q == STRM) begin
      if (cnt_q == LAST_PIX) begin
        cnt_d = '0;
        fin_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Registered from the next state so the strobe is glitch-free and rises
    // on an edge where address/data do not move.
    we_d = (state_d == STROBE);
  end

  assign Address     = addr_q;
  assign Data_In     = data_q;
  assign WriteEnable = we_q;
  assign finish      = fin_q;
  assign busy        = (state_q != ARB);

endmodule

// File: tb/tb_ram_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ram_write_scheduler
// Directed bench for ram_write_scheduler with a 4-pixel frame. Expected
// grant order follows ROUND_ROBIN_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_ram_write_scheduler;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int FRAME  = 4;

  logic              Clock;
  logic              Rst;
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              strm_valid;
  logic              strm_ready;
  logic [DATA_W-1:0] strm_data;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data_In;
  logic              WriteEnable;
  logic              finish;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  ram_write_scheduler #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .FRAME_PIXELS (FRAME)
  ) dut (
    .Clock       (Clock),
    .Rst         (Rst),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .strm_valid  (strm_valid),
    .strm_ready  (strm_ready),
    .strm_data   (strm_data),
    .Address     (Address),
    .Data_In     (Data_In),
    .WriteEnable (WriteEnable),
    .finish      (finish),
    .busy        (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(Address), 32'h0);
    chk({tag, "_data"}, 32'(Data_In), 32'h0);
    chk({tag, "_we"},   32'(WriteEnable), 32'h0);
    chk({tag, "_fin"},  32'(finish), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_hrdy"}, 32'(host_ready), 32'h0);
    chk({tag, "_srdy"}, 32'(strm_ready), 32'h0);
  endtask

  // One isolated stream beat starting in ARB; returns in the next ARB cycle.
  task automatic strm_beat(input logic [7:0] d, input logic [31:0] exp_addr);
    strm_valid = 1'b1;
    strm_data  = d;
    #1;
    chk("sb_ready", 32'(strm_ready), 32'h1);
    tick();
    strm_valid = 1'b0;
    chk("sb_addr", 32'(Address), exp_addr);
    chk("sb_data", 32'(Data_In), 32'(d));
    chk("sb_setup_we", 32'(WriteEnable), 32'h0);
    tick();
    chk("sb_strobe_we", 32'(WriteEnable), 32'h1);
    tick();
    chk("sb_arb_we", 32'(WriteEnable), 32'h0);
  endtask

  logic [5:0] exp_grant;  // bit i: 1 = stream wins transfer i
  int         exp_cnt;
  int         waited;
  logic       got_strm;
  logic [31:0] exp_addr;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst        = 1'b0;
    host_valid = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    strm_valid = 1'b0;
    strm_data  = '0;

    // Reset state.
    #22;
    chk_all_zero("rst");
    Rst = 1'b1;
    tick();

    // Single host beat.
    host_valid = 1'b1;
    host_addr  = 18'h00010;
    host_data  = 8'hA5;
    #1;
    chk("h_ready", 32'(host_ready), 32'h1);
    chk("h_sready", 32'(strm_ready), 32'h0);
    tick();
    host_valid = 1'b0;
    chk("h_addr", 32'(Address), 32'h10);
    chk("h_data", 32'(Data_In), 32'hA5);
    chk("h_setup_we", 32'(WriteEnable), 32'h0);
    chk("h_busy", 32'(busy), 32'h1);
    tick();
    chk("h_strobe_we", 32'(WriteEnable), 32'h1);
    chk("h_strobe_addr", 32'(Address), 32'h10);
    tick();
    chk("h_arb_we", 32'(WriteEnable), 32'h0);
    chk("h_arb_busy", 32'(busy), 32'h0);
    host_valid = 1'b1;
    #1;
    chk("h_ready_again", 32'(host_ready), 32'h1);
    host_valid = 1'b0;
    #1;
    chk("h_noready_novalid", 32'(host_ready), 32'h0);

    // Full 4-pixel frame.
    strm_beat(8'h11, 32'h0);
    chk("f_nofin1", 32'(finish), 32'h0);
    strm_beat(8'h22, 32'h1);
    strm_beat(8'h33, 32'h2);
    chk("f_nofin3", 32'(finish), 32'h0);
    strm_beat(8'h44, 32'h3);
    // Finish cycle: both sources valid, neither is granted.
    host_valid = 1'b1;
    host_addr  = 18'h00003;
    host_data  = 8'h5A;
    strm_valid = 1'b1;
    #1;
    chk("f_fin", 32'(finish), 32'h1);
    chk("f_fin_hrdy", 32'(host_ready), 32'h0);
    chk("f_fin_srdy", 32'(strm_ready), 32'h0);
    strm_valid = 1'b0;
    tick();
    chk("f_fin_clear", 32'(finish), 32'h0);
    chk("f_host_after", 32'(host_ready), 32'h1);
    tick();
    host_valid = 1'b0;
    chk("f_host_addr", 32'(Address), 32'h3);
    chk("f_host_data", 32'(Data_In), 32'h5A);
    tick();
    tick();
    chk("f_no_refin", 32'(finish), 32'h0);
    strm_beat(8'h55, 32'h0);
    chk("f_no_fin5", 32'(finish), 32'h0);

    // Reset during STROBE (stream count is 1 here).
    strm_valid = 1'b1;
    strm_data  = 8'h99;
    tick();
    strm_valid = 1'b0;
    chk("r_setup_addr", 32'(Address), 32'h1);
    tick();
    chk("r_strobe_we", 32'(WriteEnable), 32'h1);
    #2;
    Rst = 1'b0;
    #1;
    chk_all_zero("r_async");
    tick();
    tick();
    Rst = 1'b1;
    tick();
    chk("r_busy_after", 32'(busy), 32'h0);

    // Contention: both valid continuously for 6 transfers.
`ifdef ROUND_ROBIN_EN
    exp_grant = 6'b010101;
`else
    exp_grant = 6'b111111;
`endif
    exp_cnt    = 0;
    host_valid = 1'b1;
    host_addr  = 18'h00ABC;
    host_data  = 8'hC3;
    strm_valid = 1'b1;
    strm_data  = 8'h77;
    #1;
    for (int i = 0; i < 6; i++) begin
      waited = 0;
      while (!host_ready && !strm_ready && waited < 4) begin
        tick();
        waited++;
      end
      if (waited >= 4) chk("c_timeout", 32'(waited), 32'h0);
      got_strm = strm_ready;
      chk("c_grant", 32'(got_strm), 32'(exp_grant[i]));
      chk("c_onehot", 32'(host_ready & strm_ready), 32'h0);
      if (exp_grant[i]) begin
        exp_addr = 32'(exp_cnt);
        exp_cnt  = (exp_cnt == FRAME - 1) ? 0 : exp_cnt + 1;
      end else begin
        exp_addr = 32'h00ABC;
      end
      tick();
      chk("c_addr", 32'(Address), exp_addr);
      tick();
      chk("c_we", 32'(WriteEnable), 32'h1);
      tick();
      #1;
    end
    host_valid = 1'b0;
    strm_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_write_scheduler.md
# ram_write_scheduler

Write-side controller for the single-port frame RAM behind the image-processing accelerator. Arbitrates between a host loader port (addressed writes) and the accelerator's result stream (sequential addresses). Sequences each accepted beat into a setup/strobe pair, because the RAM captures on the rising edge of its write-enable. Emits a one-cycle finish pulse after the last pixel of a frame so the RAM dumps its contents.

## Interface
- ADDR_W, 18, RAM address width
- DATA_W, 8, pixel width
- FRAME_PIXELS, 262144, stream beats per frame; range 1..2^ADDR_W
- Clock  in  1  sole clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- host_valid  in  1  host beat present
- host_ready  out  1  host beat accepted when valid & ready
- host_addr  in  ADDR_W  host write address
- host_data  in  DATA_W  host write data
- strm_valid  in  1  stream beat present
- strm_ready  out  1  stream beat accepted when valid & ready
- strm_data  in  DATA_W  stream pixel
- Address  out  ADDR_W  to RAM Address
- Data_In  out  DATA_W  to RAM Data_In
- WriteEnable  out  1  to RAM WriteEnable; registered, glitch-free
- finish  out  1  to RAM finish; one-cycle pulse per frame
- busy  out  1  high in SETUP and STROBE

## Operation
- FSM states are ARB, SETUP and STROBE. Reset state is ARB.
- ARB: WriteEnable=0.
  - If finish=0, the arbiter grants one valid requester. Only that requester's ready is high (combinational from valid and state).
  - On transfer, Address and Data_In are registered (host: host_addr/host_data; stream: strm_count/strm_data). Next state is SETUP.
  - With no valid requester, stay in ARB. Address and Data_In hold their last values.
- SETUP: WriteEnable=0. Address and Data_In are stable. Next state is STROBE.
- STROBE: WriteEnable=1. Next state is ARB.
- Stream counter strm_count (ADDR_W bits) increments on leaving STROBE for a stream beat.
  - At FRAME_PIXELS-1 it wraps to 0 and sets finish for the following ARB cycle.
- finish cycle: both readys are forced low. finish clears after one cycle.
- Host writes never affect strm_count or finish.
- Address, Data_In and WriteEnable never change on the same edge that WriteEnable rises.
- Both valid in ARB: the winner is chosen per the Configuration section. The grant history register last_grant resets to HOST.
- Reset mid-operation (Rst low):
  - WriteEnable drops asynchronously. An in-flight beat is lost; it was already accepted, and the source is not re-asked.
  - State goes to ARB, strm_count and last_grant are cleared, and finish=0.

## Timing
- Reset values: Address=0, Data_In=0, WriteEnable=0, finish=0, busy=0, host_ready=0, strm_ready=0.
- ready is a combinational function of valid in ARB. No ready is asserted without its valid.
- Transfer on edge T:
  - SETUP during T..T+1.
  - WriteEnable rises at T+1 and falls at T+2.
  - Back in ARB at T+2, ready for the next grant.
- Throughput: one write per 3 cycles.
- finish is high for exactly the ARB cycle after the frame's last STROBE. The earliest next transfer is one cycle later.
- A source may drop valid without a transfer. The arbiter re-evaluates every ARB cycle.

## Configuration
- ROUND_ROBIN_EN defined:
  - Both valid → grant the requester not in last_grant. last_grant updates on every transfer.
  - First contention after reset goes to the stream.
- Not defined:
  - Fixed priority, stream always wins. last_grant is unused.
  - The host may starve while the stream is continuously valid.

## Structure
- Shared package ram_sched_pkg holds:
  - state enum (ARB, SETUP, STROBE)
  - requester enum (HOST, STRM)
  - default ADDR_W, DATA_W, FRAME_PIXELS constants
- One sub-module, ram_sched_arbiter: a 2-way grant from the valid bits and last_grant. It contains the ROUND_ROBIN_EN ifdef and is purely combinational apart from last_grant.

## Test plan
- Reset: Rst low mid-frame → all outputs 0 immediately. After release, the first stream beat writes Address 0.
- Single host beat addr 0x00010, data 0xA5 on edge T:
  - Address=0x00010 and Data_In=0xA5 after T.
  - WriteEnable high exactly T+1..T+2.
  - host_ready high again at T+2.
- Contention, both valid continuously, 6 transfers:
  - With ROUND_ROBIN_EN, grants are S,H,S,H,S,H.
  - Without it, grants are S,S,S,S,S,S and host_ready is never high.
- FRAME_PIXELS=4, stream data 0x11,0x22,0x33,0x44:
  - Addresses 0,1,2,3.
  - finish is a single-cycle pulse in the ARB cycle after the 4th strobe, with both readys low then.
  - Fifth beat writes Address 0.
- Rst asserted during STROBE → WriteEnable low without waiting for Clock. State is ARB, and strm_count=0 after release.
- Host valid held during the finish cycle → host_ready low that cycle. Accepted the next cycle; finish is not repeated.
